// File: rtl/hls_fp32_sub_pkg.sv
// Shared constants and types for the fp32 subtract arbiter slice.
package hls_fp32_sub_pkg;

  localparam int FP32_W            = 32;
  localparam int DEFAULT_TAG_DEPTH = 4;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/hls_fp32_sub_arb_tagfifo.sv
// In-flight requester-tag FIFO: remembers which requester owns each result
// the core will return, in issue order.
module hls_fp32_sub_arb_tagfifo
  import hls_fp32_sub_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  req_id_t                push_id,
  output req_id_t                head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_id_t            mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign count   = count_r;
  assign head_id = mem_r[rd_ptr_r];
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;

  // Tag storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hls_fp32_sub_arb.sv
// Two-requester round-robin front end for one shared fp32_sub core.
// Optional FP32_SUB_ARB_STALL_CNT_EN adds per-requester stall counters.
module hls_fp32_sub_arb
  import hls_fp32_sub_pkg::*;
#(
  parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              req0_vld,
  output logic              req0_rdy,
  input  logic [FP32_W-1:0] req0_a,
  input  logic [FP32_W-1:0] req0_b,
  input  logic              req1_vld,
  output logic              req1_rdy,
  input  logic [FP32_W-1:0] req1_a,
  input  logic [FP32_W-1:0] req1_b,
  output logic              core_in_vld,
  input  logic              core_in_rdy,
  output logic [FP32_W-1:0] core_a_z,
  output logic [FP32_W-1:0] core_b_z,
  input  logic              core_o_vld,
  output logic              core_o_rdy,
  input  logic [FP32_W-1:0] core_o_z,
  output logic              rsp0_vld,
  input  logic              rsp0_rdy,
  output logic [FP32_W-1:0] rsp0_z,
  output logic              rsp1_vld,
  input  logic              rsp1_rdy,
  output logic [FP32_W-1:0] rsp1_z,
  output logic              busy
`ifdef FP32_SUB_ARB_STALL_CNT_EN
  ,
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
`endif
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  req_id_t            rr_r;
  logic               grant0_s;
  logic               grant1_s;
  logic               fire_s;
  logic               pop_s;
  req_id_t            head_id_s;
  logic               tag_full_s;
  logic               tag_empty_s;
  logic [CNT_W-1:0]   tag_count_s;

  // Preferred requester wins when valid; the other only fills an idle slot.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rr_r == REQ0) begin
      grant0_s = req0_vld;
      grant1_s = ~req0_vld & req1_vld;
    end else begin
      grant1_s = req1_vld;
      grant0_s = ~req1_vld & req0_vld;
    end
  end

  // Full is checked on the registered count only, so rsp_rdy never reaches core_in_vld.
  assign core_in_vld = (req0_vld | req1_vld) & ~tag_full_s & ~nvdla_core_rst;
  assign fire_s      = core_in_vld & core_in_rdy;
  assign req0_rdy    = fire_s & grant0_s;
  assign req1_rdy    = fire_s & grant1_s;
  assign core_a_z    = grant1_s ? req1_a : req0_a;
  assign core_b_z    = grant1_s ? req1_b : req0_b;

  // Route the core result to the requester named by the head tag.
  always_comb begin
    rsp0_vld   = 1'b0;
    rsp1_vld   = 1'b0;
    core_o_rdy = 1'b0;
    if (!nvdla_core_rst && !tag_empty_s) begin
      if (head_id_s == REQ1) begin
        rsp1_vld   = core_o_vld;
        core_o_rdy = rsp1_rdy;
      end else begin
        rsp0_vld   = core_o_vld;
        core_o_rdy = rsp0_rdy;
      end
    end else begin
      core_o_rdy = 1'b0;
    end
  end

  assign rsp0_z = core_o_z;
  assign rsp1_z = core_o_z;
  assign pop_s  = core_o_vld & core_o_rdy;
  assign busy   = (tag_count_s != {CNT_W{1'b0}}) & ~nvdla_core_rst;

  // Round-robin pointer moves to the requester that just lost.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rr_r <= REQ0;
    end else if (fire_s) begin
      rr_r <= grant0_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  hls_fp32_sub_arb_tagfifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tagfifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (fire_s),
    .pop     (pop_s),
    .push_id (grant1_s),
    .head_id (head_id_s),
    .full    (tag_full_s),
    .empty   (tag_empty_s),
    .count   (tag_count_s)
  );

`ifdef FP32_SUB_ARB_STALL_CNT_EN
  // Stall counters: clear beats increment, saturate at all-ones.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst || stall_clr) begin
      stall_cnt0 <= 16'h0000;
      stall_cnt1 <= 16'h0000;
    end else begin
      if (req0_vld && !req0_rdy && (stall_cnt0 != 16'hFFFF)) begin
        stall_cnt0 <= stall_cnt0 + 16'h0001;
      end
      if (req1_vld && !req1_rdy && (stall_cnt1 != 16'hFFFF)) begin
        stall_cnt1 <= stall_cnt1 + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hls_fp32_sub_arb.sv
// Randomized scoreboard bench for hls_fp32_sub_arb; the bench also plays the fp32_sub core.
module tb_hls_fp32_sub_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nvdla_core_rst = 1'b1;
  logic        req0_vld = 1'b0, req1_vld = 1'b0;
  logic        req0_rdy, req1_rdy;
  logic [31:0] req0_a = 32'h0, req0_b = 32'h0, req1_a = 32'h0, req1_b = 32'h0;
  logic        core_in_vld;
  logic        core_in_rdy = 1'b0;
  logic [31:0] core_a_z, core_b_z;
  logic        core_o_vld = 1'b0;
  logic        core_o_rdy;
  logic [31:0] core_o_z = 32'h0;
  logic        rsp0_vld, rsp1_vld;
  logic        rsp0_rdy = 1'b0, rsp1_rdy = 1'b0;
  logic [31:0] rsp0_z, rsp1_z;
  logic        busy;
`ifdef FP32_SUB_ARB_STALL_CNT_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt0, stall_cnt1;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] core_q[$];
  bit          model_ids[$];
  bit          model_rr = 1'b0;

  always #5 clk = ~clk;

  hls_fp32_sub_arb #(.TAG_DEPTH(DEPTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (nvdla_core_rst),
    .req0_vld (req0_vld), .req0_rdy (req0_rdy), .req0_a (req0_a), .req0_b (req0_b),
    .req1_vld (req1_vld), .req1_rdy (req1_rdy), .req1_a (req1_a), .req1_b (req1_b),
    .core_in_vld (core_in_vld), .core_in_rdy (core_in_rdy),
    .core_a_z (core_a_z), .core_b_z (core_b_z),
    .core_o_vld (core_o_vld), .core_o_rdy (core_o_rdy), .core_o_z (core_o_z),
    .rsp0_vld (rsp0_vld), .rsp0_rdy (rsp0_rdy), .rsp0_z (rsp0_z),
    .rsp1_vld (rsp1_vld), .rsp1_rdy (rsp1_rdy), .rsp1_z (rsp1_z),
    .busy (busy)
`ifdef FP32_SUB_ARB_STALL_CNT_EN
    , .stall_clr (stall_clr), .stall_cnt0 (stall_cnt0), .stall_cnt1 (stall_cnt1)
`endif
  );

  // Integer-valued fp32 encode/decode; operands stay small so a-b is exact.
  function automatic logic [31:0] fp_of(input int v);
    logic [31:0] r;
    int m;
    int e;
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 24; i++) if ((m >> i) != 0) e = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'(m << (23 - e));
    return r;
  endfunction

  function automatic int int_of(input logic [31:0] f);
    int e;
    int m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({9'h001, f[22:0]});
    m = m >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of random stimulus checked against the spec-level model.
  task automatic step(input int p0, input int p1, input int pin, input int pcore,
                      input int prsp, input bit fixed);
    bit g1, e_vld, e_fire, has_head, head, e_ordy;
    int cnt;
    logic [31:0] sa, sb;
    @(negedge clk);
    nvdla_core_rst = 1'b0;
    req0_vld    = ($urandom_range(0, 99) < p0);
    req1_vld    = ($urandom_range(0, 99) < p1);
    req0_a      = fixed ? fp_of(3) : fp_of(int'($urandom_range(0, 1000)));
    req0_b      = fixed ? fp_of(1) : fp_of(int'($urandom_range(0, 1000)));
    req1_a      = fp_of(int'($urandom_range(0, 1000)));
    req1_b      = fp_of(int'($urandom_range(0, 1000)));
    core_in_rdy = ($urandom_range(0, 99) < pin);
    rsp0_rdy    = ($urandom_range(0, 99) < prsp);
    rsp1_rdy    = ($urandom_range(0, 99) < prsp);
    core_o_vld  = (core_q.size() > 0) && ($urandom_range(0, 99) < pcore);
    core_o_z    = (core_q.size() > 0) ? core_q[0] : $urandom;
    #1;
    cnt      = model_ids.size();
    e_vld    = (req0_vld || req1_vld) && (cnt < DEPTH);
    g1       = (model_rr == 1'b0) ? (!req0_vld && req1_vld) : req1_vld;
    e_fire   = e_vld && core_in_rdy;
    has_head = (cnt > 0);
    head     = has_head ? model_ids[0] : 1'b0;
    e_ordy   = has_head && (head ? rsp1_rdy : rsp0_rdy);
    sa       = g1 ? req1_a : req0_a;
    sb       = g1 ? req1_b : req0_b;
    chk1("core_in_vld", core_in_vld, e_vld);
    chk1("req0_rdy", req0_rdy, e_fire && !g1);
    chk1("req1_rdy", req1_rdy, e_fire && g1);
    if (e_vld) begin
      chk32("core_a_z", core_a_z, sa);
      chk32("core_b_z", core_b_z, sb);
    end
    chk1("core_o_rdy", core_o_rdy, e_ordy);
    chk1("rsp0_vld", rsp0_vld, has_head && !head && core_o_vld);
    chk1("rsp1_vld", rsp1_vld, has_head && head && core_o_vld);
    chk1("busy", busy, cnt != 0);
    if (e_fire) begin
      if (g1) exp_q1.push_back(fp_of(int_of(sa) - int_of(sb)));
      else    exp_q0.push_back(fp_of(int_of(sa) - int_of(sb)));
      core_q.push_back(fp_of(int_of(core_a_z) - int_of(core_b_z)));
      model_ids.push_back(g1);
      model_rr = !g1;
    end
    if (core_o_vld && e_ordy) begin
      void'(model_ids.pop_front());
      void'(core_q.pop_front());
    end
  endtask

  // Reset cycle with everything else pushing hard; all handshakes must stay low.
  task automatic reset_cycle();
    @(negedge clk);
    nvdla_core_rst = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1; core_in_rdy = 1'b1;
    core_o_vld = 1'b1; rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
    #1;
    chk1("rst core_in_vld", core_in_vld, 1'b0);
    chk1("rst req0_rdy", req0_rdy, 1'b0);
    chk1("rst req1_rdy", req1_rdy, 1'b0);
    chk1("rst rsp0_vld", rsp0_vld, 1'b0);
    chk1("rst rsp1_vld", rsp1_vld, 1'b0);
    chk1("rst core_o_rdy", core_o_rdy, 1'b0);
    chk1("rst busy", busy, 1'b0);
    model_ids.delete();
    exp_q0.delete();
    exp_q1.delete();
    model_rr = 1'b0;
  endtask

  // Monitor: every accepted response is popped from its requester's queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rsp0_vld && rsp0_rdy) begin
        if (exp_q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp0_unexpected: got %h expected none", rsp0_z);
        end else begin
          chk32("rsp0_z", rsp0_z, exp_q0.pop_front());
        end
      end
      if (rsp1_vld && rsp1_rdy) begin
        if (exp_q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp1_unexpected: got %h expected none", rsp1_z);
        end else begin
          chk32("rsp1_z", rsp1_z, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    reset_cycle();
    reset_cycle();
    // Both requesters saturating, core always ready: strict alternation.
    for (int i = 0; i < 12; i++) step(100, 100, 100, 100, 100, 1'b1);
    // Only requester 1 valid straight after reset.
    reset_cycle();
    core_q.delete();
    for (int i = 0; i < 6; i++) step(0, 100, 100, 100, 100, 1'b0);
    // Core silent: tag FIFO fills to DEPTH and stops issue.
    for (int i = 0; i < 6; i++) step(100, 100, 100, 0, 100, 1'b0);
    for (int i = 0; i < 4; i++) step(100, 100, 100, 100, 100, 1'b0);
    // Responders sometimes stalled: head-of-line blocking on the other port.
    for (int i = 0; i < 300; i++) step(80, 80, 90, 80, 40, 1'b0);
    for (int i = 0; i < 1500; i++)
      step(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)),
           int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
           int'($urandom_range(10, 100)), 1'b0);
    // Reset with three tags in flight, then a stray core result.
    reset_cycle();
    core_q.delete();
    for (int i = 0; i < 3; i++) step(100, 100, 100, 0, 100, 1'b0);
    reset_cycle();
    if (core_q.size() == 0) core_q.push_back(fp_of(7));
    step(0, 0, 100, 100, 100, 1'b0);
    core_q.delete();
    for (int i = 0; i < 200; i++) step(70, 70, 80, 70, 70, 1'b0);
    // Drain within a bounded number of cycles.
    guard = 0;
    while ((model_ids.size() != 0) && (guard < 100)) begin
      step(0, 0, 100, 100, 100, 1'b0);
      guard++;
    end
    step(0, 0, 100, 100, 100, 1'b0);
    chk1("drain_timeout", guard < 100, 1'b1);
    chk32("drain_q0", exp_q0.size(), 32'd0);
    chk32("drain_q1", exp_q1.size(), 32'd0);
`ifdef FP32_SUB_ARB_STALL_CNT_EN
    @(negedge clk);
    stall_clr = 1'b1; req0_vld = 1'b1; req1_vld = 1'b0; core_in_rdy = 1'b0; core_o_vld = 1'b0;
    @(negedge clk);
    stall_clr = 1'b0;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    #1;
    chk32("stall_cnt0_sat", 32'(stall_cnt0), 32'h0000_FFFF);
    chk32("stall_cnt1_idle", 32'(stall_cnt1), 32'h0000_0000);
    @(negedge clk);
    stall_clr = 1'b1;
    @(negedge clk);
    #1;
    chk32("stall_cnt0_clr", 32'(stall_cnt0), 32'h0000_0000);
    stall_clr = 1'b0;
    req0_vld = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
